fpu_dispatch_ctrl: RTL

Sits directly downstream of the host control interface (HCI) register block, between it and the FPU arithmetic core. Consumes the HCI command fields, operands and doorbell/reset requests. Sequences one or more lane operations on the core (SIMD split for half/byte formats) and assembles the 32-bit result and sticky exception flags. Returns the doorbell/reset clear handshakes and the fpu_ready level that the HCI uses for status and interrupt.

---
 rtl/fpu_dispatch_ctrl.sv | 254 +++++++++++++++++++++++++
 1 files changed

// File: rtl/fpu_dispatch_ctrl.sv
// fpu_dispatch_ctrl
// Sequences HCI commands onto the FPU arithmetic core. A command is split into
// one or more lane operations (SIMD for half/byte formats); lane results are
// packed into a 32-bit word and core exception flags are OR-accumulated.
// Soft reset from the HCI has priority over everything else. A WAIT watchdog
// aborts a hung core. The doorbell/reset handshakes idle at 1 and drop for a
// single cycle to clear the matching HCI command bit.

module fpu_dispatch_ctrl #(
    parameter int RST_CYCLES     = 4,
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TIMER_W        = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        fpu_rst_w,
    input  logic        fpu_doorbell_w,
    input  logic [1:0]  fpu_format,
    input  logic [1:0]  fpu_operation,
    input  logic        fpu_fused_m_a,
    input  logic        fpu_simd,
    input  logic [2:0]  fpu_simd_no_op,
    input  logic [31:0] fpu_operand_a,
    input  logic [31:0] fpu_operand_b,
    input  logic [31:0] fpu_operand_c,
    output logic        fpu_rst_r,
    output logic        fpu_doorbell_r,
    output logic [31:0] fpu_output,
    output logic        fpu_invalid_op_flag_0,
    output logic        fpu_overflow_flag_0,
    output logic        fpu_underflow_flag_0,
    output logic        fpu_inexact_flag_0,
    output logic        fpu_ready,
    output logic        core_srst,
    output logic        core_start,
    output logic [1:0]  core_format,
    output logic [1:0]  core_operation,
    output logic        core_fused_m_a,
    output logic [31:0] core_a,
    output logic [31:0] core_b,
    output logic [31:0] core_c,
    input  logic        core_done,
    input  logic [31:0] core_result,
    input  logic [3:0]  core_flags
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_COMPLETE,
        S_DONE,
        S_RESET,
        S_RST_ACK
    } state_t;

    localparam logic [TIMER_W-1:0] RST_LAST     = TIMER_W'(RST_CYCLES - 1);
    localparam logic [TIMER_W-1:0] TIMEOUT_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);

    state_t              state;
    logic [31:0]         a_q;
    logic [31:0]         b_q;
    logic [31:0]         c_q;
    logic [1:0]          lane_idx;
    logic [2:0]          lane_cnt;
    logic [TIMER_W-1:0]  timer;
    logic [3:0]          flags;     // {inexact, underflow, overflow, invalid}
    logic                accept;

    // Select lane idx of a packed operand, right-aligned and zero-extended.
    function automatic logic [31:0] lane_extract(input logic [31:0] word,
                                                 input logic [1:0]  fmt,
                                                 input logic [1:0]  idx);
        logic [31:0] r;
        r = '0;
        case (fmt)
            2'b00:   r = word;
            2'b01:   r = {16'h0000, word[{idx[0], 4'b0000} +: 16]};
            2'b10:   r = {24'h000000, word[{idx, 3'b000} +: 8]};
            default: r = '0;
        endcase
        return r;
    endfunction

    // Place the low lane-width bits of a core result into lane idx of acc.
    function automatic logic [31:0] lane_insert(input logic [31:0] acc,
                                                input logic [31:0] res,
                                                input logic [1:0]  fmt,
                                                input logic [1:0]  idx);
        logic [31:0] r;
        r = acc;
        case (fmt)
            2'b00:   r = res;
            2'b01:   r[{idx[0], 4'b0000} +: 16] = res[15:0];
            2'b10:   r[{idx, 3'b000} +: 8] = res[7:0];
            default: r = acc;
        endcase
        return r;
    endfunction

    // Number of lane operations: 1 without SIMD, else the request with 0
    // read as 1 and clamped to the lanes that fit in 32 bits.
    function automatic logic [2:0] lane_count(input logic [1:0] fmt,
                                              input logic       simd,
                                              input logic [2:0] req);
        logic [2:0] max_n;
        logic [2:0] n;
        case (fmt)
            2'b01:   max_n = 3'd2;
            2'b10:   max_n = 3'd4;
            default: max_n = 3'd1;
        endcase
        if (!simd || (req == 3'd0)) begin
            n = 3'd1;
        end else if (req > max_n) begin
            n = max_n;
        end else begin
            n = req;
        end
        return n;
    endfunction

    // A new command is taken only from IDLE/DONE and never alongside a soft reset.
    assign accept = ((state == S_IDLE) || (state == S_DONE)) && fpu_doorbell_w && !fpu_rst_w;

    assign fpu_invalid_op_flag_0 = flags[0];
    assign fpu_overflow_flag_0   = flags[1];
    assign fpu_underflow_flag_0  = flags[2];
    assign fpu_inexact_flag_0    = flags[3];

    // Operand snapshot taken at command acceptance; later host writes do not reach the core.
    always_ff @(posedge clk) begin
        if (accept) begin
            a_q <= fpu_operand_a;
            b_q <= fpu_operand_b;
            c_q <= fpu_operand_c;
        end
    end

    // Dispatch FSM with all outputs registered.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= S_IDLE;
            fpu_rst_r      <= 1'b1;
            fpu_doorbell_r <= 1'b1;
            fpu_output     <= '0;
            flags          <= '0;
            fpu_ready      <= 1'b0;
            core_srst      <= 1'b0;
            core_start     <= 1'b0;
            core_format    <= '0;
            core_operation <= '0;
            core_fused_m_a <= 1'b0;
            core_a         <= '0;
            core_b         <= '0;
            core_c         <= '0;
            lane_idx       <= '0;
            lane_cnt       <= '0;
            timer          <= '0;
        end else begin
            core_start <= 1'b0;
            if (fpu_rst_w && (state != S_RESET) && (state != S_RST_ACK)) begin
                // Soft reset aborts whatever is in flight.
                state          <= S_RESET;
                core_srst      <= 1'b1;
                timer          <= '0;
                fpu_output     <= '0;
                flags          <= '0;
                fpu_ready      <= 1'b0;
                fpu_doorbell_r <= 1'b1;
            end else begin
                case (state)
                    S_IDLE, S_DONE: begin
                        if (accept) begin
                            state          <= S_ISSUE;
                            core_format    <= fpu_format;
                            core_operation <= fpu_operation;
                            core_fused_m_a <= fpu_fused_m_a;
                            core_start     <= (fpu_format != 2'b11);
                            core_a         <= lane_extract(fpu_operand_a, fpu_format, 2'd0);
                            core_b         <= lane_extract(fpu_operand_b, fpu_format, 2'd0);
                            core_c         <= lane_extract(fpu_operand_c, fpu_format, 2'd0);
                            lane_idx       <= '0;
                            lane_cnt       <= lane_count(fpu_format, fpu_simd, fpu_simd_no_op);
                            fpu_output     <= '0;
                            flags          <= '0;
                            fpu_ready      <= 1'b0;
                        end
                    end
                    S_ISSUE: begin
                        timer <= '0;
                        if (core_format == 2'b11) begin
                            // Reserved format: nothing is sent to the core.
                            flags[0]       <= 1'b1;
                            fpu_output     <= '0;
                            fpu_doorbell_r <= 1'b0;
                            state          <= S_COMPLETE;
                        end else begin
                            state <= S_WAIT;
                        end
                    end
                    S_WAIT: begin
                        if (core_done) begin
                            fpu_output <= lane_insert(fpu_output, core_result, core_format, lane_idx);
                            flags      <= flags | core_flags;
                            if (({1'b0, lane_idx} + 3'd1) < lane_cnt) begin
                                lane_idx   <= lane_idx + 2'd1;
                                core_start <= 1'b1;
                                core_a     <= lane_extract(a_q, core_format, lane_idx + 2'd1);
                                core_b     <= lane_extract(b_q, core_format, lane_idx + 2'd1);
                                core_c     <= lane_extract(c_q, core_format, lane_idx + 2'd1);
                                state      <= S_ISSUE;
                            end else begin
                                fpu_doorbell_r <= 1'b0;
                                state          <= S_COMPLETE;
                            end
                        end else if (timer == TIMEOUT_LAST) begin
                            // Hung core: kick it with a one-cycle reset and report invalid.
                            core_srst      <= 1'b1;
                            flags[0]       <= 1'b1;
                            fpu_doorbell_r <= 1'b0;
                            state          <= S_COMPLETE;
                        end else begin
                            timer <= timer + 1'b1;
                        end
                    end
                    S_COMPLETE: begin
                        fpu_doorbell_r <= 1'b1;
                        core_srst      <= 1'b0;
                        fpu_ready      <= 1'b1;
                        state          <= S_DONE;
                    end
                    S_RESET: begin
                        if (timer == RST_LAST) begin
                            core_srst <= 1'b0;
                            fpu_rst_r <= 1'b0;
                            state     <= S_RST_ACK;
                        end else begin
                            timer <= timer + 1'b1;
                        end
                    end
                    S_RST_ACK: begin
                        fpu_rst_r <= 1'b1;
                        state     <= S_IDLE;
                    end
                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
